// File: rtl/md_unit_pkg.sv
// md_unit_pkg: MD opcode encodings and control state type shared with decode.
package md_unit_pkg;
    localparam logic [2:0] MD_mult  = 3'd0;
    localparam logic [2:0] MD_multu = 3'd1;
    localparam logic [2:0] MD_div   = 3'd2;
    localparam logic [2:0] MD_divu  = 3'd3;
    localparam logic [2:0] MD_mthi  = 3'd4;
    localparam logic [2:0] MD_mtlo  = 3'd5;
    typedef enum logic {IDLE, RUN} md_state_t;
endpackage

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers, results committed after a fixed latency.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] In0,
    input  logic [WIDTH-1:0] In1,
    input  logic [2:0]       MDOp,
    input  logic             Start,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    md_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] ph, pl, ph_n, pl_n, hi_n, lo_n;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0] dsor_s, dsor_u, q_s, r_s, q_u, r_u;
    logic dz, ovf;
    assign prod_s = {{WIDTH{In0[WIDTH-1]}}, In0} * {{WIDTH{In1[WIDTH-1]}}, In1};
    assign prod_u = {{WIDTH{1'b0}}, In0} * {{WIDTH{1'b0}}, In1};
    assign dz     = In1 == '0;
    assign ovf    = In0 == {1'b1, {(WIDTH-1){1'b0}}} && In1 == '1;
    // Dividing by 1 in the overflow case yields exactly MIN / 0; zero divisor is swapped out only to keep the operator total.
    assign dsor_s = (dz || ovf) ? WIDTH'(1) : In1;
    assign dsor_u = dz ? WIDTH'(1) : In1;
    assign q_s    = $signed(In0) / $signed(dsor_s);
    assign r_s    = $signed(In0) % $signed(dsor_s);
    assign q_u    = In0 / dsor_u;
    assign r_u    = In0 % dsor_u;
    assign Busy   = state == RUN;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ph_n    = ph;
        pl_n    = pl;
        hi_n    = HI;
        lo_n    = LO;
        if (state == IDLE) begin
            if (Start) begin
                case (MDOp)
                    MD_mult: begin
                        {ph_n, pl_n} = prod_s;
                        cnt_n        = CW'(MULT_CYCLES);
                        state_n      = RUN;
                    end
                    MD_multu: begin
                        {ph_n, pl_n} = prod_u;
                        cnt_n        = CW'(MULT_CYCLES);
                        state_n      = RUN;
                    end
                    // Zero divisor reloads the current HI/LO so the commit leaves them untouched.
                    MD_div: begin
                        ph_n    = dz ? HI : r_s;
                        pl_n    = dz ? LO : q_s;
                        cnt_n   = CW'(DIV_CYCLES);
                        state_n = RUN;
                    end
                    MD_divu: begin
                        ph_n    = dz ? HI : r_u;
                        pl_n    = dz ? LO : q_u;
                        cnt_n   = CW'(DIV_CYCLES);
                        state_n = RUN;
                    end
                    MD_mthi: hi_n = In0;
                    MD_mtlo: lo_n = In0;
                    default: ;
                endcase
            end
        end else begin
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                hi_n    = ph;
                lo_n    = pl;
                state_n = IDLE;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            ph    <= '0;
            pl    <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ph    <= ph_n;
            pl    <= pl_n;
            HI    <= hi_n;
            LO    <= lo_n;
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit at default parameters and a 16-bit short-latency build.
module tb_md_unit;
    import md_unit_pkg::*;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;
    logic        clk = 0;
    logic        reset = 0;
    logic [31:0] in0 = 0, in1 = 0, hi, lo;
    logic [2:0]  mdop = 0;
    logic        start = 0, busy;
    logic [15:0] s_in0 = 0, s_in1 = 0, s_hi, s_lo;
    logic [2:0]  s_mdop = 0;
    logic        s_start = 0, s_busy;
    res_t        q[$];
    int          n_checks = 0, n_fail = 0;
    always #5 clk = ~clk;
    md_unit u32 (
        .clk(clk), .reset(reset), .In0(in0), .In1(in1), .MDOp(mdop),
        .Start(start), .Busy(busy), .HI(hi), .LO(lo)
    );
    md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) u16 (
        .clk(clk), .reset(reset), .In0(s_in0), .In1(s_in1), .MDOp(s_mdop),
        .Start(s_start), .Busy(s_busy), .HI(s_hi), .LO(s_lo)
    );
    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n_exp, input logic [31:0] eh, input logic [31:0] el, input string name);
        int n;
        res_t e;
        start = 1; mdop = op; in0 = a; in1 = b;
        q.push_back('{eh, el});
        @(posedge clk); #1;
        start = 0; in0 = $urandom; in1 = $urandom; mdop = op ^ 3'd1;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        e = q.pop_front();
        n_checks++;
        if (n !== n_exp) begin n_fail++; $display("FAIL %s busy_cycles got %0d want %0d", name, n, n_exp); end
        n_checks++;
        if (hi !== e.hi) begin n_fail++; $display("FAIL %s hi got %h want %h", name, hi, e.hi); end
        n_checks++;
        if (lo !== e.lo) begin n_fail++; $display("FAIL %s lo got %h want %h", name, lo, e.lo); end
    endtask
    task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int n_exp, input logic [15:0] eh, input logic [15:0] el, input string name);
        int n;
        res_t e;
        s_start = 1; s_mdop = op; s_in0 = a; s_in1 = b;
        q.push_back('{{16'h0, eh}, {16'h0, el}});
        @(posedge clk); #1;
        s_start = 0; s_in0 = 16'($urandom); s_in1 = 16'($urandom);
        n = 0;
        while (s_busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        e = q.pop_front();
        n_checks++;
        if (n !== n_exp) begin n_fail++; $display("FAIL %s busy_cycles got %0d want %0d", name, n, n_exp); end
        n_checks++;
        if ({16'h0, s_hi} !== e.hi) begin n_fail++; $display("FAIL %s hi got %h want %h", name, s_hi, e.hi); end
        n_checks++;
        if ({16'h0, s_lo} !== e.lo) begin n_fail++; $display("FAIL %s lo got %h want %h", name, s_lo, e.lo); end
    endtask
    task automatic idle_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] eh,
                           input logic [31:0] el, input string name);
        start = 1; mdop = op; in0 = a;
        @(posedge clk); #1;
        start = 0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy got %b want 0", name, busy); end
        n_checks++;
        if (hi !== eh) begin n_fail++; $display("FAIL %s hi got %h want %h", name, hi, eh); end
        n_checks++;
        if (lo !== el) begin n_fail++; $display("FAIL %s lo got %h want %h", name, lo, el); end
    endtask
    task automatic test_reset;
        #2 reset = 1;
        #10 reset = 0;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, hi, lo} !== 65'h0) begin n_fail++; $display("FAIL reset_state got %b/%h/%h want 0/0/0", busy, hi, lo); end
        n_checks++;
        if ({s_busy, s_hi, s_lo} !== 33'h0) begin n_fail++; $display("FAIL reset_state16 got %b/%h/%h want 0/0/0", s_busy, s_hi, s_lo); end
        run32(MD_mult, 3, 5, 5, 32'h0, 32'd15, "mult_3x5");
    endtask
    task automatic test_reset_mid_run;
        start = 1; mdop = MD_mult; in0 = 3; in1 = 5;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #3;
        reset = 1;
        #1;
        n_checks++;
        if ({busy, hi, lo} !== 65'h0) begin n_fail++; $display("FAIL reset_mid_run got %b/%h/%h want 0/0/0", busy, hi, lo); end
        #3 reset = 0;
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, hi, lo} !== 65'h0) begin n_fail++; $display("FAIL reset_no_commit got %b/%h/%h want 0/0/0", busy, hi, lo); end
    endtask
    task automatic test_mult_sign;
        run32(MD_mult, 32'hFFFFFFFF, 2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult_neg");
        run32(MD_multu, 32'hFFFFFFFF, 2, 5, 32'h00000001, 32'hFFFFFFFE, "multu");
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a, b;
            logic [63:0] p;
            a = $urandom; b = $urandom;
            p = longint'($signed(a)) * longint'($signed(b));
            run32(MD_mult, a, b, 5, p[63:32], p[31:0], "mult_rand");
        end
    endtask
    task automatic test_div_corner;
        run32(MD_div, -32'sd7, 2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2");
        run32(MD_div, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000, "div_ovf");
        run32(MD_div, 32'd7, -32'sd2, 10, 32'h1, 32'hFFFFFFFD, "div_7_neg2");
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom_range(1, 32'h7FFFFFFF) >> $urandom_range(0, 28);
            if (b == 0) b = 3;
            run32(MD_divu, a, b, 10, a % b, a / b, "divu_rand");
        end
    endtask
    task automatic test_div_zero;
        idle_op(MD_mthi, 32'h1234, 32'h1234, lo, "mthi");
        idle_op(MD_mtlo, 32'h5678, 32'h1234, 32'h5678, "mtlo");
        idle_op(3'd7, 32'hDEAD, 32'h1234, 32'h5678, "undef_op");
        run32(MD_divu, 32'd99, 0, 10, 32'h1234, 32'h5678, "divu_zero");
        run32(MD_div, 32'd99, 0, 10, 32'h1234, 32'h5678, "div_zero");
    endtask
    task automatic test_busy_ignore;
        int n;
        logic seen;
        start = 1; mdop = MD_mult; in0 = 6; in1 = 7;
        q.push_back('{32'h0, 32'd42});
        @(posedge clk); #1;
        start = 0;
        n = 1; seen = 0;
        @(posedge clk); #1;
        n++;
        start = 1; mdop = MD_mthi; in0 = 32'hAAAA;
        @(posedge clk); #1;
        n++;
        mdop = MD_div; in0 = 100; in1 = 3;
        @(posedge clk); #1;
        n++;
        start = 0;
        while (busy && n < 100) begin
            if (hi == 32'hAAAA) seen = 1;
            @(posedge clk); #1;
            if (busy) n++;
        end
        if (hi == 32'hAAAA) seen = 1;
        n_checks++;
        if (n !== 5) begin n_fail++; $display("FAIL busy_ignore cycles got %0d want 5", n); end
        begin
            res_t e;
            e = q.pop_front();
            n_checks++;
            if ({hi, lo} !== {e.hi, e.lo}) begin n_fail++; $display("FAIL busy_ignore hilo got %h/%h want %h/%h", hi, lo, e.hi, e.lo); end
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL busy_ignore mthi_taken got %b want 0", seen); end
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, hi, lo} !== {1'b0, 32'h0, 32'd42}) begin n_fail++; $display("FAIL busy_ignore late got %b/%h/%h want 0/0/2a", busy, hi, lo); end
    endtask
    task automatic test_back_to_back;
        run32(MD_multu, 32'h10000, 32'h10000, 5, 32'h1, 32'h0, "b2b_multu");
        run32(MD_divu, 32'd100, 32'd7, 10, 32'd2, 32'd14, "b2b_divu");
    endtask
    task automatic test_sweep;
        run16(MD_multu, 16'hFFFF, 16'hFFFF, 1, 16'hFFFE, 16'h0001, "w16_multu");
        run16(MD_divu, 16'd100, 16'd7, 3, 16'd2, 16'd14, "w16_divu");
        run16(MD_mult, 16'hFFFF, 16'd3, 1, 16'hFFFF, 16'hFFFD, "w16_mult");
        run16(MD_div, 16'h8000, 16'hFFFF, 3, 16'h0, 16'h8000, "w16_div_ovf");
    endtask
    initial begin
        test_reset;
        test_reset_mid_run;
        test_mult_sign;
        test_div_corner;
        test_div_zero;
        test_busy_ignore;
        test_back_to_back;
        test_sweep;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
